ex_stage_unit: RTL and testbench

//  Execute stage: consumer side of the ID/EX pipeline register. Takes decoded operands and

---
 rtl/ex_stage_unit.sv | 196 +++++++++++++++++++
 tb/tb_ex_stage_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_unit.sv
// Execute stage: forwarding muxes, ALU, iterative multiplier and the EX/MEM register.
// A multi-cycle MUL holds the front of the pipe through stall_o while EX/MEM takes bubbles.
module ex_stage_unit #(
  parameter int MUL_LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic        ALUsrc_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [31:0] instruction_i,
  input  logic [31:0] RS1data_i,
  input  logic [31:0] RS2data_i,
  input  logic [31:0] sign_ext_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        MemWrite_i,
  input  logic        MemRead_i,
  input  logic        MemtoReg_i,
  input  logic        RegWrite_i,
  input  logic [1:0]  fwdA_i,
  input  logic [1:0]  fwdB_i,
  input  logic [31:0] exmem_data_i,
  input  logic [31:0] memwb_data_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] ALUresult_o,
  output logic [31:0] MemWdata_o,
  output logic [4:0]  RDaddr_o,
  output logic        MemWrite_o,
  output logic        MemRead_o,
  output logic        MemtoReg_o,
  output logic        RegWrite_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BUSY  = 1'b1;
  localparam logic       MUL_ITER = (MUL_LATENCY > 1) ? 1'b1 : 1'b0;
  localparam logic [4:0] CNT_INIT = (MUL_LATENCY > 1) ? 5'(MUL_LATENCY - 2) : 5'd0;

  function automatic logic [31:0] fwd_sel(input logic [1:0]  sel,
                                          input logic [31:0] idex_val,
                                          input logic [31:0] exmem_val,
                                          input logic [31:0] memwb_val);
    case (sel)
      2'b10:   fwd_sel = exmem_val;
      2'b01:   fwd_sel = memwb_val;
      default: fwd_sel = idex_val;
    endcase
  endfunction

  logic [6:0]  funct7_s;
  logic [2:0]  funct3_s;
  logic [31:0] op_a_s;
  logic [31:0] op_b_s;
  logic [31:0] rs2_fwd_s;
  logic [31:0] alu_res_s;
  logic [31:0] mul_prod_s;
  logic        is_mul_s;
  logic        start_mul_s;
  logic        unused_s;
  logic [0:0]  state_r;
  logic [4:0]  cnt_r;
  logic [31:0] mul_a_r;
  logic [31:0] mul_b_r;

  assign funct7_s   = instruction_i[31:25];
  assign funct3_s   = instruction_i[14:12];
  assign unused_s   = ^{instruction_i[24:15], instruction_i[11:0]};
  assign op_a_s     = fwd_sel(fwdA_i, RS1data_i, exmem_data_i, memwb_data_i);
  assign rs2_fwd_s  = fwd_sel(fwdB_i, RS2data_i, exmem_data_i, memwb_data_i);
  assign op_b_s     = ALUsrc_i ? sign_ext_i : rs2_fwd_s;
  // The multiplier only ever sees the operands captured at issue, never the live forwards.
  assign mul_prod_s = mul_a_r * mul_b_r;
  assign start_mul_s = valid_i & is_mul_s & MUL_ITER & (state_r == ST_IDLE) & ~flush_i;

  // ALU operation decode and single-cycle result
  always_comb begin
    alu_res_s = 32'd0;
    is_mul_s  = 1'b0;
    case (ALUOp_i)
      2'b00: alu_res_s = op_a_s + op_b_s;
      2'b01: alu_res_s = op_a_s - op_b_s;
      2'b10: begin
        case ({funct7_s, funct3_s})
          10'b0000000_000: alu_res_s = op_a_s + op_b_s;
          10'b0100000_000: alu_res_s = op_a_s - op_b_s;
          10'b0000000_111: alu_res_s = op_a_s & op_b_s;
          10'b0000000_100: alu_res_s = op_a_s ^ op_b_s;
          10'b0000000_001: alu_res_s = op_a_s << op_b_s[4:0];
          10'b0000001_000: begin
            alu_res_s = op_a_s * op_b_s;
            is_mul_s  = 1'b1;
          end
          default:         alu_res_s = 32'd0;
        endcase
      end
      2'b11: begin
        case (funct3_s)
          3'b000: alu_res_s = op_a_s + op_b_s;
          3'b101: begin
            if (funct7_s == 7'b0100000) begin
              alu_res_s = 32'($signed(op_a_s) >>> op_b_s[4:0]);
            end else begin
              alu_res_s = 32'd0;
            end
          end
          default: alu_res_s = 32'd0;
        endcase
      end
      default: alu_res_s = 32'd0;
    endcase
  end

  // Stall request: flush and reset always release the front of the pipe
  always_comb begin
    if (rst_i) begin
      stall_o = 1'b0;
    end else if (flush_i) begin
      stall_o = 1'b0;
    end else if (state_r == ST_BUSY) begin
      stall_o = (cnt_r != 5'd0);
    end else begin
      stall_o = start_mul_s;
    end
  end

  // Multiplier FSM and EX/MEM pipeline register; bubbles clear valid and side-effect controls only
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 5'd0;
      mul_a_r     <= 32'd0;
      mul_b_r     <= 32'd0;
      valid_o     <= 1'b0;
      ALUresult_o <= 32'd0;
      MemWdata_o  <= 32'd0;
      RDaddr_o    <= 5'd0;
      MemWrite_o  <= 1'b0;
      MemRead_o   <= 1'b0;
      MemtoReg_o  <= 1'b0;
      RegWrite_o  <= 1'b0;
    end else if (flush_i) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 5'd0;
      valid_o    <= 1'b0;
      RegWrite_o <= 1'b0;
      MemWrite_o <= 1'b0;
      MemRead_o  <= 1'b0;
    end else begin
      case (state_r)
        ST_BUSY: begin
          if (cnt_r != 5'd0) begin
            cnt_r      <= cnt_r - 5'd1;
            valid_o    <= 1'b0;
            RegWrite_o <= 1'b0;
            MemWrite_o <= 1'b0;
            MemRead_o  <= 1'b0;
          end else begin
            state_r     <= ST_IDLE;
            valid_o     <= valid_i;
            ALUresult_o <= mul_prod_s;
            MemWdata_o  <= rs2_fwd_s;
            RDaddr_o    <= RDaddr_i;
            MemWrite_o  <= MemWrite_i & valid_i;
            MemRead_o   <= MemRead_i & valid_i;
            MemtoReg_o  <= MemtoReg_i & valid_i;
            RegWrite_o  <= RegWrite_i & valid_i;
          end
        end
        default: begin
          if (start_mul_s) begin
            state_r    <= ST_BUSY;
            cnt_r      <= CNT_INIT;
            mul_a_r    <= op_a_s;
            mul_b_r    <= op_b_s;
            valid_o    <= 1'b0;
            RegWrite_o <= 1'b0;
            MemWrite_o <= 1'b0;
            MemRead_o  <= 1'b0;
          end else begin
            valid_o     <= valid_i;
            ALUresult_o <= alu_res_s;
            MemWdata_o  <= rs2_fwd_s;
            RDaddr_o    <= RDaddr_i;
            MemWrite_o  <= MemWrite_i & valid_i;
            MemRead_o   <= MemRead_i & valid_i;
            MemtoReg_o  <= MemtoReg_i & valid_i;
            RegWrite_o  <= RegWrite_i & valid_i;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage_unit.sv
// Scoreboard bench for ex_stage_unit: expected EX/MEM contents are queued as each
// instruction is driven and compared one cycle later when the register updates.
module tb_ex_stage_unit;

  localparam int LAT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, flush_i, ALUsrc_i;
  logic [1:0]  ALUOp_i, fwdA_i, fwdB_i;
  logic [31:0] instruction_i, RS1data_i, RS2data_i, sign_ext_i, exmem_data_i, memwb_data_i;
  logic [4:0]  RDaddr_i;
  logic        MemWrite_i, MemRead_i, MemtoReg_i, RegWrite_i;
  logic        stall_o, valid_o;
  logic [31:0] ALUresult_o, MemWdata_o;
  logic [4:0]  RDaddr_o;
  logic        MemWrite_o, MemRead_o, MemtoReg_o, RegWrite_o;

  typedef struct {
    string       tag;
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] mwd;
    logic        chk;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_i = ~clk_i;

  ex_stage_unit #(.MUL_LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
    .ALUsrc_i(ALUsrc_i), .ALUOp_i(ALUOp_i), .instruction_i(instruction_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .sign_ext_i(sign_ext_i),
    .RDaddr_i(RDaddr_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
    .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i), .fwdA_i(fwdA_i), .fwdB_i(fwdB_i),
    .exmem_data_i(exmem_data_i), .memwb_data_i(memwb_data_i), .stall_o(stall_o),
    .valid_o(valid_o), .ALUresult_o(ALUresult_o), .MemWdata_o(MemWdata_o),
    .RDaddr_o(RDaddr_o), .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o),
    .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3);
    mk_instr = {f7, 10'd0, f3, 12'd0};
  endfunction

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    if (op == 0)      ref_alu = a + b;
    else if (op == 1) ref_alu = a - b;
    else if (op == 2) ref_alu = a & b;
    else if (op == 3) ref_alu = a ^ b;
    else              ref_alu = a << b[4:0];
  endfunction

  task automatic clear_inputs();
    valid_i = 1'b0; flush_i = 1'b0; ALUsrc_i = 1'b0; ALUOp_i = 2'b00;
    instruction_i = 32'd0; RS1data_i = 32'd0; RS2data_i = 32'd0; sign_ext_i = 32'd0;
    exmem_data_i = 32'd0; memwb_data_i = 32'd0; RDaddr_i = 5'd0; fwdA_i = 2'b00; fwdB_i = 2'b00;
    MemWrite_i = 1'b0; MemRead_i = 1'b0; MemtoReg_i = 1'b0; RegWrite_i = 1'b0;
  endtask

  task automatic push_exp(input string tag, input logic v, input logic rw, input logic [4:0] rd,
                          input logic [31:0] res, input logic [31:0] mwd, input logic chk);
    exp_t e;
    e.tag = tag; e.v = v; e.rw = rw; e.rd = rd; e.res = res; e.mwd = mwd; e.chk = chk;
    sb_q.push_back(e);
  endtask

  task automatic push_bubble(input string tag);
    push_exp(tag, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // Check stall before the edge, then pop and compare the EX/MEM register after it.
  task automatic run_cycle(input logic exp_stall);
    exp_t e;
    #1;
    check_val("stall", {31'd0, stall_o}, {31'd0, exp_stall});
    @(posedge clk_i);
    #1;
    check_val("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({e.tag, ".valid"}, {31'd0, valid_o}, {31'd0, e.v});
      check_val({e.tag, ".regwrite"}, {31'd0, RegWrite_o}, {31'd0, e.rw});
      if (e.chk) begin
        check_val({e.tag, ".result"}, ALUresult_o, e.res);
        check_val({e.tag, ".wdata"}, MemWdata_o, e.mwd);
        check_val({e.tag, ".rd"}, {27'd0, RDaddr_o}, {27'd0, e.rd});
      end
    end
    @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".valid"}, {31'd0, valid_o}, 32'd0);
    check_val({tag, ".stall"}, {31'd0, stall_o}, 32'd0);
    check_val({tag, ".result"}, ALUresult_o, 32'd0);
    check_val({tag, ".wdata"}, MemWdata_o, 32'd0);
    check_val({tag, ".rd"}, {27'd0, RDaddr_o}, 32'd0);
    check_val({tag, ".ctl"}, {28'd0, MemWrite_o, MemRead_o, MemtoReg_o, RegWrite_o}, 32'd0);
  endtask

  initial begin
    clear_inputs();
    rst_i = 1'b0;
    #1 rst_i = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    clear_inputs(); valid_i = 1'b1; RS1data_i = 32'd5; RS2data_i = 32'd7;
    RegWrite_i = 1'b1; RDaddr_i = 5'd3;
    push_exp("add", 1'b1, 1'b1, 5'd3, 32'd12, 32'd7, 1'b1); run_cycle(1'b0);

    clear_inputs(); valid_i = 1'b1; ALUOp_i = 2'b01; fwdA_i = 2'b10; exmem_data_i = 32'd100;
    RS1data_i = 32'd55; RS2data_i = 32'd1; RegWrite_i = 1'b1; RDaddr_i = 5'd4;
    push_exp("sub_fwd", 1'b1, 1'b1, 5'd4, 32'd99, 32'd1, 1'b1); run_cycle(1'b0);

    clear_inputs(); valid_i = 1'b1; ALUOp_i = 2'b11; instruction_i = mk_instr(7'b0100000, 3'b101);
    ALUsrc_i = 1'b1; sign_ext_i = 32'd4; RS1data_i = 32'h8000_0000; RS2data_i = 32'h55;
    RegWrite_i = 1'b1; RDaddr_i = 5'd7;
    push_exp("srai", 1'b1, 1'b1, 5'd7, 32'hF800_0000, 32'h55, 1'b1); run_cycle(1'b0);

    clear_inputs(); valid_i = 1'b1; ALUOp_i = 2'b11; ALUsrc_i = 1'b1; RS1data_i = 32'd16;
    sign_ext_i = 32'd8; fwdB_i = 2'b01; memwb_data_i = 32'hDEAD_BEEF; RS2data_i = 32'h11;
    MemWrite_i = 1'b1; RDaddr_i = 5'd0;
    push_exp("store", 1'b1, 1'b0, 5'd0, 32'd24, 32'hDEAD_BEEF, 1'b1); run_cycle(1'b0);

    clear_inputs(); valid_i = 1'b1; fwdA_i = 2'b11; fwdB_i = 2'b11; RS1data_i = 32'd10;
    RS2data_i = 32'd1; exmem_data_i = 32'd999; memwb_data_i = 32'd888;
    RegWrite_i = 1'b1; RDaddr_i = 5'd8;
    push_exp("fwd11", 1'b1, 1'b1, 5'd8, 32'd11, 32'd1, 1'b1); run_cycle(1'b0);

    clear_inputs(); valid_i = 1'b1; ALUOp_i = 2'b10; instruction_i = mk_instr(7'b0100000, 3'b111);
    RS1data_i = 32'hFFFF; RS2data_i = 32'h1234; RegWrite_i = 1'b1; RDaddr_i = 5'd2;
    push_exp("unlisted", 1'b1, 1'b1, 5'd2, 32'd0, 32'h1234, 1'b1); run_cycle(1'b0);

    clear_inputs(); ALUOp_i = 2'b10; instruction_i = mk_instr(7'b0000001, 3'b000);
    RS1data_i = 32'd3; RS2data_i = 32'd3; RegWrite_i = 1'b1; RDaddr_i = 5'd1;
    push_bubble("invalid_mul"); run_cycle(1'b0);

    // MUL whose rs1 is forwarded from EX/MEM; the forward changes while stalled
    clear_inputs(); valid_i = 1'b1; ALUOp_i = 2'b10; instruction_i = mk_instr(7'b0000001, 3'b000);
    fwdA_i = 2'b10; exmem_data_i = 32'd3; RS1data_i = 32'd77; RS2data_i = 32'hFFFF_FFFC;
    RegWrite_i = 1'b1; RDaddr_i = 5'd9;
    push_bubble("mul_issue"); run_cycle(1'b1);
    exmem_data_i = 32'd1234;
    for (int i = 1; i <= LAT - 2; i++) begin
      push_bubble("mul_busy"); run_cycle(1'b1);
    end
    push_exp("mul", 1'b1, 1'b1, 5'd9, 32'hFFFF_FFF4, 32'hFFFF_FFFC, 1'b1); run_cycle(1'b0);
    clear_inputs();
    push_bubble("mul_after"); run_cycle(1'b0);

    clear_inputs(); valid_i = 1'b1; ALUOp_i = 2'b10; instruction_i = mk_instr(7'b0000001, 3'b000);
    RS1data_i = 32'd6; RS2data_i = 32'd7; RegWrite_i = 1'b1; RDaddr_i = 5'd10;
    push_bubble("flush_issue"); run_cycle(1'b1);
    flush_i = 1'b1;
    push_bubble("flush"); run_cycle(1'b0);
    clear_inputs(); valid_i = 1'b1; RS1data_i = 32'd2; RS2data_i = 32'd2;
    RegWrite_i = 1'b1; RDaddr_i = 5'd11;
    push_exp("post_flush", 1'b1, 1'b1, 5'd11, 32'd4, 32'd2, 1'b1); run_cycle(1'b0);
    clear_inputs();
    push_bubble("flush_idle"); run_cycle(1'b0);

    clear_inputs(); valid_i = 1'b1; RS1data_i = 32'd20; RS2data_i = 32'd22;
    RegWrite_i = 1'b1; RDaddr_i = 5'd5;
    push_exp("pre_rst", 1'b1, 1'b1, 5'd5, 32'd42, 32'd22, 1'b1); run_cycle(1'b0);
    clear_inputs(); valid_i = 1'b1; ALUOp_i = 2'b10; instruction_i = mk_instr(7'b0000001, 3'b000);
    RS1data_i = 32'd3; RS2data_i = 32'd5; RegWrite_i = 1'b1; RDaddr_i = 5'd12;
    push_bubble("rst_mul_issue"); run_cycle(1'b1);
    rst_i = 1'b1;
    #1 check_reset_outputs("mid_mul_rst");
    clear_inputs();
    rst_i = 1'b0;
    valid_i = 1'b1; RS1data_i = 32'd1; RS2data_i = 32'd2; RegWrite_i = 1'b1; RDaddr_i = 5'd6;
    push_exp("post_rst", 1'b1, 1'b1, 5'd6, 32'd3, 32'd2, 1'b1); run_cycle(1'b0);

    for (int k = 0; k < 8; k++) begin
      int op;
      logic [31:0] a, b;
      op = k % 5;
      a = $urandom();
      b = $urandom();
      clear_inputs(); valid_i = 1'b1; RS1data_i = a; RS2data_i = b;
      RegWrite_i = 1'b1; RDaddr_i = 5'(k + 13);
      if (op == 1) ALUOp_i = 2'b01;
      else if (op >= 2) begin
        ALUOp_i = 2'b10;
        if (op == 2)      instruction_i = mk_instr(7'b0000000, 3'b111);
        else if (op == 3) instruction_i = mk_instr(7'b0000000, 3'b100);
        else              instruction_i = mk_instr(7'b0000000, 3'b001);
      end
      push_exp("rand", 1'b1, 1'b1, 5'(k + 13), ref_alu(op, a, b), b, 1'b1);
      run_cycle(1'b0);
    end

    clear_inputs();
    push_bubble("final_idle"); run_cycle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
